// File: rtl/reject_sampler_pack.sv
// Uniform rejection sampler: filters candidate beats against q, compacts accepted
// samples into a packing buffer and drains them as keep/last-qualified output beats.
//   state   | meaning
//   S_IDLE  | waiting for start; q latched on start
//   S_RUN   | accepting candidate beats until TARGET samples are collected
//   S_FLUSH | draining the remaining buffered samples, final beat carries out_last
//   S_DONE  | one-cycle end-of-run pulse
module reject_sampler_pack #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int OUT_LANES = 4,
  parameter int BUF_SLOTS = 8,
  parameter int TARGET    = 256,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [15:0]                    q,
  input  logic [LANES*CAND_BITS-1:0]     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [OUT_LANES*CAND_BITS-1:0] out_data,
  output logic [OUT_LANES-1:0]           out_keep,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               acc_cnt,
  output logic [CNT_W-1:0]               rej_cnt
);

  localparam int FW = $clog2(BUF_SLOTS + 1);
  localparam int IW = (BUF_SLOTS > 1) ? $clog2(BUF_SLOTS) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t               state_q;
  logic [15:0]          q_q;
  logic [FW-1:0]        fill_q, fill_d;
  logic [CAND_BITS-1:0] buf_q [BUF_SLOTS];
  logic [CAND_BITS-1:0] buf_d [BUF_SLOTS];
  logic [CAND_BITS-1:0] comp  [LANES];
  logic [CNT_W-1:0]     acc_q, acc_d, rej_q, rej_d;
  logic [CNT_W:0]       rej_sum;
  logic [CAND_BITS-1:0] cand;
  logic                 in_fire, out_fire;
  int                   fill_i, n_vis, n_acc, take, popped, pushed, rem, k;

  always_comb begin
    fill_i    = int'(fill_q);
    n_vis     = (fill_i < OUT_LANES) ? fill_i : OUT_LANES;
    in_ready  = (state_q == S_RUN) && (fill_i <= BUF_SLOTS - LANES);
    out_valid = 1'b0;
    out_keep  = '0;
    out_last  = 1'b0;
    case (state_q)
      S_RUN: begin
        out_valid = (fill_i >= OUT_LANES);
        out_keep  = '1;
      end
      S_FLUSH: begin
        out_valid = (fill_i > 0);
        out_keep  = OUT_LANES'((1 << n_vis) - 1);
        out_last  = (fill_i > 0) && (fill_i <= OUT_LANES);
      end
      default: ;
    endcase
    out_data = '0;
    for (int s = 0; s < OUT_LANES; s++) begin
      if (out_keep[s]) out_data[s*CAND_BITS +: CAND_BITS] = buf_q[s];
    end

    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    // Compact accepted lanes in lane order; lanes beyond the remaining quota are dropped.
    n_acc = 0;
    for (int i = 0; i < LANES; i++) begin
      cand = in_data[i*CAND_BITS +: CAND_BITS];
      if (32'(cand) < 32'(q_q)) n_acc = n_acc + 1;
    end
    take = TARGET - int'(acc_q);
    if (n_acc < take) take = n_acc;
    k = 0;
    for (int i = 0; i < LANES; i++) comp[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      cand = in_data[i*CAND_BITS +: CAND_BITS];
      if (32'(cand) < 32'(q_q)) begin
        if (k < take) comp[LW'(k)] = cand;
        k = k + 1;
      end
    end

    popped = out_fire ? n_vis : 0;
    pushed = in_fire ? take : 0;
    rem    = fill_i - popped;
    for (int j = 0; j < BUF_SLOTS; j++) begin
      buf_d[j] = '0;
      if (j + popped < fill_i)
        buf_d[j] = buf_q[IW'(j + popped)];
      else if ((j >= rem) && (j < rem + pushed))
        buf_d[j] = comp[LW'(j - rem)];
    end
    fill_d = FW'(rem + pushed);

    acc_d   = acc_q + CNT_W'(pushed);
    rej_sum = {1'b0, rej_q} + (CNT_W+1)'(in_fire ? (LANES - n_acc) : 0);
    rej_d   = rej_sum[CNT_W] ? '1 : rej_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      rej_q   <= '0;
      for (int j = 0; j < BUF_SLOTS; j++) buf_q[j] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            q_q     <= q;
            fill_q  <= '0;
            acc_q   <= '0;
            rej_q   <= '0;
            for (int j = 0; j < BUF_SLOTS; j++) buf_q[j] <= '0;
          end
        end
        S_RUN: begin
          buf_q  <= buf_d;
          fill_q <= fill_d;
          acc_q  <= acc_d;
          rej_q  <= rej_d;
          if (in_fire && (int'(acc_d) == TARGET)) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          buf_q  <= buf_d;
          fill_q <= fill_d;
          if (out_fire && out_last) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign acc_cnt = acc_q;
  assign rej_cnt = rej_q;

endmodule

// File: tb/tb_reject_sampler_pack.sv
// Randomized scoreboard bench for reject_sampler_pack; a second instance with
// TARGET=6 covers the partial final beat.
module tb_reject_sampler_pack;
  localparam int LANES = 4;
  localparam int CB    = 12;
  localparam int OL    = 4;
  localparam int BS    = 8;
  localparam int TGT   = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] q = '0;
  logic [47:0] in_data = '0;
  logic        in_ready, out_last, out_valid, busy, done;
  logic [47:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] acc_cnt, rej_cnt;

  logic        b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [47:0] b_in_data = '0;
  logic        b_in_ready, b_out_last, b_out_valid, b_busy, b_done;
  logic [47:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic [15:0] b_acc_cnt, b_rej_cnt;

  reject_sampler_pack dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .acc_cnt(acc_cnt), .rej_cnt(rej_cnt));

  reject_sampler_pack #(.TARGET(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .q(16'hFFFF),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy), .done(b_done), .acc_cnt(b_acc_cnt), .rej_cnt(b_rej_cnt));

  int checks = 0, failures = 0;

  // Reference model: accepted samples in arrival order, plus expected counters.
  logic [11:0] exp_q[$];
  int          acc_m = 0, rej_m = 0, q_m = 0;
  bit          model_live = 1'b0;
  int          done_cnt = 0, out_beats = 0, in_beats = 0;
  logic [3:0]  last_keep = '0;
  logic        last_last = 1'b0;
  bit          last_fire = 1'b0, held = 1'b0, complete;
  logic [47:0] hd, ed;
  logic [3:0]  hk;
  logic        hl;
  logic [11:0] cand;
  int          sz, nv, na;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and input-side model share one block so the queue depth equals the DUT fill.
  always @(negedge clk) begin
    if (!rst_n || !model_live) begin
      held      = 1'b0;
      last_fire = 1'b0;
    end else begin
      sz       = exp_q.size();
      complete = (acc_m >= TGT);
      chk("acc_cnt", 64'(acc_cnt), 64'(acc_m));
      chk("rej_cnt", 64'(rej_cnt), 64'(rej_m));
      chk("out_valid", 64'(out_valid), 64'(complete ? (sz > 0) : (sz >= OL)));
      chk("in_ready", 64'(in_ready), 64'(!complete && (sz <= BS - LANES)));
      chk("done", 64'(done), 64'(last_fire));
      if (done) done_cnt++;
      last_fire = 1'b0;
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(hd));
        chk("hold_keep", 64'(out_keep), 64'(hk));
        chk("hold_last", 64'(out_last), 64'(hl));
      end
      held = 1'b0;
      if (out_valid) begin
        nv = complete ? ((sz < OL) ? sz : OL) : OL;
        ed = '0;
        for (int s = 0; s < OL; s++)
          if (s < nv && s < sz) ed[s*CB +: CB] = exp_q[s];
        chk("beat_data", 64'(out_data), 64'(ed));
        chk("beat_keep", 64'(out_keep), 64'((1 << nv) - 1));
        chk("beat_last", 64'(out_last), 64'(complete && (sz <= OL)));
        if (out_ready) begin
          for (int s = 0; s < nv; s++)
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          out_beats++;
          last_keep = out_keep;
          last_last = out_last;
          last_fire = complete && (sz <= OL);
        end else begin
          held = 1'b1;
          hd   = out_data;
          hk   = out_keep;
          hl   = out_last;
        end
      end
      if (in_valid && in_ready) begin
        in_beats++;
        na = 0;
        for (int i = 0; i < LANES; i++) begin
          cand = in_data[i*CB +: CB];
          if (int'(cand) < q_m) begin
            na++;
            if (acc_m < TGT) begin
              exp_q.push_back(cand);
              acc_m++;
            end
          end
        end
        rej_m = (rej_m + LANES - na > 65535) ? 65535 : rej_m + LANES - na;
      end
    end
  end

  task automatic do_start(input logic [15:0] qv);
    @(posedge clk); #1;
    model_live = 1'b0;
    start = 1'b1; q = qv; in_valid = 1'b0;
    q_m = int'(qv); acc_m = 0; rej_m = 0;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    model_live = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; model_live = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_beat(input bit below_q);
    for (int i = 0; i < LANES; i++)
      in_data[i*CB +: CB] = below_q ? 12'($urandom_range(q_m - 1)) : 12'($urandom_range(4095));
  endtask

  task automatic drive_run(input int vpct, input int rpct, input bit below_q, input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < vpct);
      rand_beat(below_q);
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      n++;
    end
    chk("run_completed", 64'(done_cnt != d0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ob0, ib0;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_keep", 64'({out_keep, out_last, in_ready, busy, done}), 64'(0));
    chk("rst_counters", 64'({acc_cnt, rej_cnt}), 64'(0));
    chk("rst_b_outputs", 64'({b_out_valid, b_out_keep, b_busy, b_done, b_in_ready}), 64'(0));
    rst_n = 1'b1;

    // Single mixed beat, then random traffic to completion
    do_start(16'd3329);
    in_valid = 1'b1;
    in_data  = {12'd3328, 12'd3329, 12'd4095, 12'd0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_acc", 64'(acc_cnt), 64'(2));
    chk("t1_rej", 64'(rej_cnt), 64'(2));
    chk("t1_out_valid", 64'(out_valid), 64'(0));
    drive_run(50, 50, 1'b0, 5000);

    // All accept at full rate: one beat per cycle
    ob0 = out_beats; ib0 = in_beats; d0 = done_cnt;
    do_start(16'd3329);
    drive_run(100, 100, 1'b1, 2000);
    repeat (3) @(negedge clk);
    chk("t2_in_beats", 64'(in_beats - ib0), 64'(64));
    chk("t2_out_beats", 64'(out_beats - ob0), 64'(64));
    chk("t2_last_keep", 64'(last_keep), 64'(4'hF));
    chk("t2_last_flag", 64'(last_last), 64'(1));
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("t2_idle", 64'(busy), 64'(0));

    // Backpressure: buffer fills, in_ready drops, beat is held
    do_start(16'd3329);
    out_ready = 1'b0;
    repeat (6) begin
      in_valid = 1'b1;
      rand_beat(1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_in_ready_low", 64'(in_ready), 64'(0));
    chk("t4_out_valid", 64'(out_valid), 64'(1));
    drive_run(50, 50, 1'b1, 5000);

    // q above the candidate range: every candidate accepts
    do_start(16'h2000);
    drive_run(60, 70, 1'b0, 3000);
    chk("bigq_rej", 64'(rej_cnt), 64'(0));

    // Reset mid-run with three samples buffered
    do_start(16'd3329);
    in_valid = 1'b1;
    in_data  = {12'd30, 12'd4000, 12'd20, 12'd10};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_acc_before", 64'(acc_cnt), 64'(3));
    #2;
    rst_n = 1'b0;
    model_live = 1'b0;
    #1;
    chk("t6_data_zero", 64'(out_data), 64'(0));
    chk("t6_ctrl_zero", 64'({out_valid, out_keep, out_last, in_ready, busy, done}), 64'(0));
    chk("t6_cnt_zero", 64'({acc_cnt, rej_cnt}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start(16'd3329);
    @(negedge clk);
    chk("t6_restart_acc", 64'(acc_cnt), 64'(0));
    chk("t6_restart_busy", 64'(busy), 64'(1));
    drive_run(50, 50, 1'b0, 5000);

    // q=0: nothing accepts, reject counter saturates
    do_start(16'd0);
    in_valid = 1'b1;
    repeat (16400) begin
      rand_beat(1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_rej", 64'(rej_cnt), 64'(16'hFFFF));
    chk("sat_acc", 64'(acc_cnt), 64'(0));
    chk("sat_busy", 64'(busy), 64'(1));
    do_reset();

    // TARGET=6 instance: two full beats, surplus lanes dropped
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = {12'd4, 12'd3, 12'd2, 12'd1};
    @(negedge clk);
    chk("b_ready1", 64'(b_in_ready), 64'(1));
    @(posedge clk); #1;
    b_in_data = {12'd8, 12'd7, 12'd6, 12'd5};
    @(negedge clk);
    chk("b_ready2", 64'(b_in_ready), 64'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_acc", 64'(b_acc_cnt), 64'(6));
    chk("b_rej", 64'(b_rej_cnt), 64'(0));
    chk("b_in_ready_flush", 64'(b_in_ready), 64'(0));
    chk("b_beat1_valid", 64'(b_out_valid), 64'(1));
    chk("b_beat1_data", 64'(b_out_data), 64'({12'd4, 12'd3, 12'd2, 12'd1}));
    chk("b_beat1_keep", 64'(b_out_keep), 64'(4'hF));
    chk("b_beat1_last", 64'(b_out_last), 64'(0));
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("b_beat1_hold", 64'(b_out_data), 64'({12'd4, 12'd3, 12'd2, 12'd1}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_beat2_valid", 64'(b_out_valid), 64'(1));
    chk("b_beat2_data", 64'(b_out_data), 64'({12'd0, 12'd0, 12'd6, 12'd5}));
    chk("b_beat2_keep", 64'(b_out_keep), 64'(4'h3));
    chk("b_beat2_last", 64'(b_out_last), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_done", 64'(b_done), 64'(1));
    chk("b_done_valid", 64'(b_out_valid), 64'(0));
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    @(negedge clk);
    chk("b_done_single", 64'(b_done), 64'(0));
    chk("b_idle", 64'(b_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
